// File: rtl/alu_biquad_lr.sv
// alu_biquad_lr: stereo direct-form-I biquad that runs as one client of the
// shared ALU. Each accepted stereo sample is processed with five sequential
// MAC requests (p = a*b + c on both lanes). The result is shifted right by
// FRAC_W, saturated to 18 bits and presented on out_l/out_r.
//
// Optional feature: define ALU_BIQUAD_CLIP_FLAG_EN to add the clip_l/clip_r
// outputs. Each flag qualifies with out_valid and is high when its lane
// saturated.
//
// Ports:
//   clk, reset                 clock, synchronous active-high reset
//   in_valid/in_ready          input handshake (ready only while idle)
//   in_l, in_r                 signed 18-bit input samples
//   coef_b0..b2, coef_na1/na2  signed Q2.16 coefficients (na = negated a)
//   out_valid                  one-cycle pulse marking a new result
//   out_l, out_r               saturated outputs, held until the next result
//   alu_cycle                  bus lock for the whole five-op sequence
//   alu_strobe/alu_stall       request handshake
//   alu_ack, alu_pl/alu_pr     result return
//   alu_op                     constant MAC op code
//   alu_al/bl/ar/br, alu_cl/cr per-lane multiplier operands and addend
//   clip_l, clip_r             saturation flags (ALU_BIQUAD_CLIP_FLAG_EN only)
module alu_biquad_lr #(
    parameter logic [8:0]  ALU_OP_MAC = 9'd1,
    parameter int unsigned FRAC_W     = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [17:0] in_l,
    input  logic [17:0] in_r,
    input  logic [17:0] coef_b0,
    input  logic [17:0] coef_b1,
    input  logic [17:0] coef_b2,
    input  logic [17:0] coef_na1,
    input  logic [17:0] coef_na2,
    output logic        out_valid,
    output logic [17:0] out_l,
    output logic [17:0] out_r,
    output logic        alu_cycle,
    output logic        alu_strobe,
    input  logic        alu_stall,
    input  logic        alu_ack,
    output logic [8:0]  alu_op,
    output logic [17:0] alu_al,
    output logic [17:0] alu_bl,
    output logic [17:0] alu_ar,
    output logic [17:0] alu_br,
    output logic [47:0] alu_cl,
    output logic [47:0] alu_cr,
    input  logic [47:0] alu_pl,
    input  logic [47:0] alu_pr
`ifdef ALU_BIQUAD_CLIP_FLAG_EN
    ,
    output logic        clip_l,
    output logic        clip_r
`endif
);

    localparam int unsigned DW = 18;
    localparam int unsigned AW = 48;
    localparam int unsigned SW = 3;
    localparam logic signed [AW-1:0] Y_MAX = AW'(131071);
    localparam logic signed [AW-1:0] Y_MIN = AW'(-131072);

    typedef enum logic [1:0] {IDLE, REQ, WAIT_ACK} state_t;

    state_t         state_q, state_d;
    logic [SW-1:0]  step_q, step_d;

    // Current input and per-lane history
    logic [DW-1:0]  x_l_q, x_r_q, x_l_d, x_r_d;
    logic [DW-1:0]  x1_l_q, x2_l_q, y1_l_q, y2_l_q;
    logic [DW-1:0]  x1_r_q, x2_r_q, y1_r_q, y2_r_q;
    logic [DW-1:0]  x1_l_d, x2_l_d, y1_l_d, y2_l_d;
    logic [DW-1:0]  x1_r_d, x2_r_d, y1_r_d, y2_r_d;

    // b0 is consumed at accept time straight into the step-0 operands
    logic [DW-1:0]  b1_q, b2_q, na1_q, na2_q;
    logic [DW-1:0]  b1_d, b2_d, na1_d, na2_d;

    logic [AW-1:0]  acc_l_q, acc_r_q, acc_l_d, acc_r_d;

    logic           in_ready_d, out_valid_d, cycle_d, strobe_d;
    logic [DW-1:0]  out_l_d, out_r_d;
    logic [DW-1:0]  al_d, bl_d, ar_d, br_d;
    logic [DW-1:0]  y_l_c, y_r_c;

    function automatic logic [DW-1:0] sat_y(input logic [AW-1:0] acc);
        logic signed [AW-1:0] sh;
        sh = $signed(acc) >>> FRAC_W;
        if (sh > Y_MAX)      sat_y = DW'(Y_MAX);
        else if (sh < Y_MIN) sat_y = DW'(Y_MIN);
        else                 sat_y = sh[DW-1:0];
    endfunction

    // Saturated results from the final product, valid on the last ack
    assign y_l_c = sat_y(alu_pl);
    assign y_r_c = sat_y(alu_pr);

    // The accumulator is the addend; it is zeroed at accept for step 0
    assign alu_cl = acc_l_q;
    assign alu_cr = acc_r_q;
    assign alu_op = ALU_OP_MAC;

`ifdef ALU_BIQUAD_CLIP_FLAG_EN
    logic clip_l_d, clip_r_d;

    function automatic logic is_clip(input logic [AW-1:0] acc);
        logic signed [AW-1:0] sh;
        sh = $signed(acc) >>> FRAC_W;
        is_clip = (sh > Y_MAX) || (sh < Y_MIN);
    endfunction
`endif

    // Next-state and registered-output logic
    always_comb begin
        state_d     = state_q;
        step_d      = step_q;
        x_l_d       = x_l_q;
        x_r_d       = x_r_q;
        x1_l_d      = x1_l_q;
        x2_l_d      = x2_l_q;
        y1_l_d      = y1_l_q;
        y2_l_d      = y2_l_q;
        x1_r_d      = x1_r_q;
        x2_r_d      = x2_r_q;
        y1_r_d      = y1_r_q;
        y2_r_d      = y2_r_q;
        b1_d        = b1_q;
        b2_d        = b2_q;
        na1_d       = na1_q;
        na2_d       = na2_q;
        acc_l_d     = acc_l_q;
        acc_r_d     = acc_r_q;
        out_valid_d = 1'b0;
        out_l_d     = out_l;
        out_r_d     = out_r;
        cycle_d     = alu_cycle;
        strobe_d    = alu_strobe;
        al_d        = alu_al;
        bl_d        = alu_bl;
        ar_d        = alu_ar;
        br_d        = alu_br;
`ifdef ALU_BIQUAD_CLIP_FLAG_EN
        clip_l_d    = clip_l;
        clip_r_d    = clip_r;
`endif

        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    x_l_d    = in_l;
                    x_r_d    = in_r;
                    b1_d     = coef_b1;
                    b2_d     = coef_b2;
                    na1_d    = coef_na1;
                    na2_d    = coef_na2;
                    acc_l_d  = '0;
                    acc_r_d  = '0;
                    step_d   = '0;
                    al_d     = coef_b0;
                    bl_d     = in_l;
                    ar_d     = coef_b0;
                    br_d     = in_r;
                    cycle_d  = 1'b1;
                    strobe_d = 1'b1;
                    state_d  = REQ;
                end
            end

            REQ: begin
                if (!alu_stall) begin
                    strobe_d = 1'b0;
                    state_d  = WAIT_ACK;
                end
            end

            WAIT_ACK: begin
                if (alu_ack) begin
                    acc_l_d = alu_pl;
                    acc_r_d = alu_pr;
                    if (step_q == SW'(4)) begin
                        x2_l_d      = x1_l_q;
                        x1_l_d      = x_l_q;
                        y2_l_d      = y1_l_q;
                        y1_l_d      = y_l_c;
                        x2_r_d      = x1_r_q;
                        x1_r_d      = x_r_q;
                        y2_r_d      = y1_r_q;
                        y1_r_d      = y_r_c;
                        out_l_d     = y_l_c;
                        out_r_d     = y_r_c;
                        out_valid_d = 1'b1;
                        cycle_d     = 1'b0;
`ifdef ALU_BIQUAD_CLIP_FLAG_EN
                        clip_l_d    = is_clip(alu_pl);
                        clip_r_d    = is_clip(alu_pr);
`endif
                        state_d     = IDLE;
                    end else begin
                        step_d   = step_q + SW'(1);
                        strobe_d = 1'b1;
                        state_d  = REQ;
                        // Operands for the step being entered
                        case (step_q)
                            SW'(0): begin
                                al_d = b1_q;   ar_d = b1_q;
                                bl_d = x1_l_q; br_d = x1_r_q;
                            end
                            SW'(1): begin
                                al_d = b2_q;   ar_d = b2_q;
                                bl_d = x2_l_q; br_d = x2_r_q;
                            end
                            SW'(2): begin
                                al_d = na1_q;  ar_d = na1_q;
                                bl_d = y1_l_q; br_d = y1_r_q;
                            end
                            default: begin
                                al_d = na2_q;  ar_d = na2_q;
                                bl_d = y2_l_q; br_d = y2_r_q;
                            end
                        endcase
                    end
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase

        in_ready_d = (state_d == IDLE);
    end

    // State and output registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            step_q     <= '0;
            x_l_q      <= '0;
            x_r_q      <= '0;
            x1_l_q     <= '0;
            x2_l_q     <= '0;
            y1_l_q     <= '0;
            y2_l_q     <= '0;
            x1_r_q     <= '0;
            x2_r_q     <= '0;
            y1_r_q     <= '0;
            y2_r_q     <= '0;
            b1_q       <= '0;
            b2_q       <= '0;
            na1_q      <= '0;
            na2_q      <= '0;
            acc_l_q    <= '0;
            acc_r_q    <= '0;
            in_ready   <= 1'b1;
            out_valid  <= 1'b0;
            out_l      <= '0;
            out_r      <= '0;
            alu_cycle  <= 1'b0;
            alu_strobe <= 1'b0;
            alu_al     <= '0;
            alu_bl     <= '0;
            alu_ar     <= '0;
            alu_br     <= '0;
`ifdef ALU_BIQUAD_CLIP_FLAG_EN
            clip_l     <= 1'b0;
            clip_r     <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            step_q     <= step_d;
            x_l_q      <= x_l_d;
            x_r_q      <= x_r_d;
            x1_l_q     <= x1_l_d;
            x2_l_q     <= x2_l_d;
            y1_l_q     <= y1_l_d;
            y2_l_q     <= y2_l_d;
            x1_r_q     <= x1_r_d;
            x2_r_q     <= x2_r_d;
            y1_r_q     <= y1_r_d;
            y2_r_q     <= y2_r_d;
            b1_q       <= b1_d;
            b2_q       <= b2_d;
            na1_q      <= na1_d;
            na2_q      <= na2_d;
            acc_l_q    <= acc_l_d;
            acc_r_q    <= acc_r_d;
            in_ready   <= in_ready_d;
            out_valid  <= out_valid_d;
            out_l      <= out_l_d;
            out_r      <= out_r_d;
            alu_cycle  <= cycle_d;
            alu_strobe <= strobe_d;
            alu_al     <= al_d;
            alu_bl     <= bl_d;
            alu_ar     <= ar_d;
            alu_br     <= br_d;
`ifdef ALU_BIQUAD_CLIP_FLAG_EN
            clip_l     <= clip_l_d;
            clip_r     <= clip_r_d;
`endif
        end
    end

endmodule

// File: doc/alu_biquad_lr.md
# alu_biquad_lr

Stereo direct-form-I biquad filter that acts as one client of the shared ALU subsystem. It accepts left/right audio samples and issues five multiply-accumulate transactions per sample over the client bus, one at a time. It then saturates and emits the filtered samples. It sits directly upstream of the ALU's client port and occupies one client slot.

## Interface

Parameters:
- ALU_OP_MAC, 9'd1, op code the ALU core decodes as p = a*b + c on both lanes.
- FRAC_W, 16, fractional bits of coefficients; also the result right-shift amount.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high.
- in_valid  in  1  input sample present.
- in_ready  out  1  high only in IDLE.
- in_l, in_r  in  18  signed input samples.
- coef_b0, coef_b1, coef_b2  in  18  signed Q2.16 feed-forward coefficients.
- coef_na1, coef_na2  in  18  signed Q2.16 negated feedback coefficients (-a1, -a2).
- out_valid  out  1  one-cycle pulse with a new result.
- out_l, out_r  out  18  signed saturated outputs, held until the next result.
- alu_cycle  out  1  bus lock, held high for the whole five-op sequence.
- alu_strobe  out  1  request valid.
- alu_stall  in  1  request not accepted this cycle.
- alu_ack  in  1  result valid.
- alu_op  out  9  always ALU_OP_MAC.
- alu_al, alu_bl, alu_ar, alu_br  out  18  multiplier operands.
- alu_cl, alu_cr  out  48  addend.
- alu_pl, alu_pr  in  48  results.

## Operation

- States: IDLE, REQ, WAIT_ACK. A step counter runs 0..4.
- IDLE, on in_valid:
  - Capture in_l/in_r into x.
  - Latch all five coefficients; later coefficient changes do not affect the current sample.
  - Set step=0 and go to REQ. alu_cycle rises on entry to REQ.
- Operand schedule, per lane (R uses its own history, same coefficients):
  - step0: a=b0, b=x, c=0.
  - step1: a=b1, b=x1, c=acc.
  - step2: a=b2, b=x2, c=acc.
  - step3: a=na1, b=y1, c=acc.
  - step4: a=na2, b=y2, c=acc.
- REQ: alu_strobe=1 with stable operands. When strobe & !stall, the request is accepted and the state goes to WAIT_ACK.
- WAIT_ACK: alu_strobe=0. On alu_ack:
  - acc_l/acc_r <= alu_pl/alu_pr.
  - If step<4: step++ and return to REQ.
  - If step==4: go to IDLE.
- Result, on the final ack:
  - y = acc >>> FRAC_W (arithmetic), saturated to [-131072, 131071].
  - Load out_l/out_r.
  - Update history: x2<=x1, x1<=x, y2<=y1, y1<=y (saturated value).
- One transaction is outstanding at most. alu_ack seen in IDLE or REQ is ignored.
- in_valid while not in IDLE is not accepted. The upstream holds it.

## Timing

- Reset values: all outputs 0 except in_ready=1. State IDLE; x, y, acc and all history 0.
- Reset mid-sequence: on the next cycle alu_cycle and alu_strobe are 0. The partial sample is discarded, history is cleared, and a late ack is ignored.
- Each step costs 1 REQ cycle plus stall cycles plus L, where L is the ALU accept-to-ack latency (≥1).
- Latency from accept (cycle 0) to out_valid, with zero stall and L=1: 11 cycles.
  - out_valid and the IDLE re-entry occur in the same cycle.
  - alu_cycle falls that cycle and in_ready rises.
- Throughput: one stereo sample per 5*(1+L)+1 cycles minimum.

## Configuration

- ALU_BIQUAD_CLIP_FLAG_EN defined:
  - Adds outputs clip_l and clip_r (1 bit each).
  - Each is valid with out_valid and is high when that lane saturated. Reset value 0.
- ALU_BIQUAD_CLIP_FLAG_EN undefined:
  - These ports are absent.
  - Saturation behaviour is identical.

## Test plan

- Identity: b0=65536, others 0, in_l=1000, in_r=-1000, L=1, no stall -> out_l=1000, out_r=-1000, out_valid 11 cycles after accept, alu_cycle high cycles 1..10.
- Unit delay: b1=65536 only, inputs 5, 7, 9 -> outputs 0, 5, 7.
- Feedback: b0=65536, na1=32768, input 1024 then zeros -> outputs 1024, 512, 256, 128.
- Saturation: b0=131071, x=100000 -> y=131071, clip_l=1. Then x=-100000 -> y=-131072.
- Stall/busy:
  - Stimulus: alu_stall high for 3 cycles at step 2; in_valid asserted mid-sequence.
  - Required: strobe held with unchanged operands, latency 14, results equal the no-stall case, in_ready stays 0 until out_valid.
- Reset mid-op:
  - Stimulus: reset during step 3 WAIT_ACK, then an ack arrives.
  - Required: cycle/strobe 0 next cycle, ack ignored, the next identity sample 500 yields 500 with no residue.
